// File: rtl/seq_frame_scheduler_pkg.sv
// Shared types and default sizing for the serial frame scheduler and its 1011 detector.
package seq_sched_pkg;

   localparam int unsigned DEF_NUM_CH    = 4;
   localparam int unsigned DEF_FRAME_LEN = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_STREAM,
      S_DRAIN,
      S_REPORT
   } sched_state_t;

   typedef enum logic [2:0] {
      D_IDLE,
      D_SEQ_1,
      D_SEQ_10,
      D_SEQ_101,
      D_MATCH
   } det_state_t;

endpackage

// File: rtl/seq_frame_scheduler_if.sv
// Request/grant/serial-data and result handshake bundle between channels, scheduler and result consumer.
interface seq_frame_scheduler_if
   import seq_sched_pkg::*;
#(
   parameter int unsigned NUM_CH    = DEF_NUM_CH,
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
);
   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] ch_bit;
   logic [NUM_CH-1:0] gnt;
   logic              res_valid;
   logic              res_ready;
   logic [CH_W-1:0]   res_ch;
   logic [CNT_W-1:0]  res_count;

   modport master (
      output req, ch_bit, res_ready,
      input  gnt, res_valid, res_ch, res_count
   );

   modport slave (
      input  req, ch_bit, res_ready,
      output gnt, res_valid, res_ch, res_count
   );

endinterface

// File: rtl/seq_frame_scheduler_detect.sv
// Non-overlapping 1011 detector; seq_seen is high the cycle after the completing bit.
module seq_detect_1011
   import seq_sched_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic seq_seen
);

   det_state_t state, state_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= D_IDLE;
         seq_seen <= 1'b0;
      end else begin
         state    <= state_next;
         seq_seen <= (state_next == D_MATCH);
      end
   end

   // After a match the completing 1 is not reused as the start of a new sequence.
   always_comb begin
      state_next = state;
      case (state)
         D_IDLE:    state_next = din ? D_SEQ_1   : D_IDLE;
         D_SEQ_1:   state_next = din ? D_SEQ_1   : D_SEQ_10;
         D_SEQ_10:  state_next = din ? D_SEQ_101 : D_IDLE;
         D_SEQ_101: state_next = din ? D_MATCH   : D_SEQ_10;
         D_MATCH:   state_next = din ? D_SEQ_1   : D_IDLE;
         default:   state_next = D_IDLE;
      endcase
   end

endmodule

// File: rtl/seq_frame_scheduler.sv
// Round-robin frame scheduler: grants one channel for a frame, counts 1011 matches, reports the count.
module seq_frame_scheduler
   import seq_sched_pkg::*;
#(
   parameter int unsigned NUM_CH    = DEF_NUM_CH,
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
)(
   input logic                  clk,
   input logic                  reset,
   seq_frame_scheduler_if.slave bus
);

   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
   localparam int unsigned BIT_W = $clog2(FRAME_LEN);

   sched_state_t     state, state_next;
   logic [CH_W-1:0]  ch;
   logic [CH_W-1:0]  rr_ptr;
   logic [CH_W-1:0]  pick;
   logic [BIT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] count;
   logic             det_reset;
   logic             det_din;
   logic             seq_seen;

   assign det_reset     = reset || (state == S_CLR);
   assign det_din       = (state == S_STREAM) && bus.ch_bit[ch];
   assign bus.res_ch    = ch;
   assign bus.res_count = count;

   seq_detect_1011 u_detect (
      .clk      (clk),
      .reset    (det_reset),
      .din      (det_din),
      .seq_seen (seq_seen)
   );

   // First requesting channel at or after rr_ptr, wrapping.
   always_comb begin
      logic             found;
      int unsigned      j;
      logic [CH_W-1:0]  idx;
      pick  = rr_ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         j = 32'(rr_ptr) + i;
         if (j >= NUM_CH) j = j - NUM_CH;
         idx = CH_W'(j);
         if (!found && bus.req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (|bus.req) state_next = S_CLR;
         S_CLR:    state_next = S_STREAM;
         S_STREAM: if (bit_cnt == BIT_W'(FRAME_LEN - 1)) state_next = S_DRAIN;
         S_DRAIN:  state_next = S_REPORT;
         S_REPORT: if (bus.res_ready) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; gnt/res_valid follow the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         ch            <= '0;
         rr_ptr        <= '0;
         bit_cnt       <= '0;
         count         <= '0;
         bus.gnt       <= '0;
         bus.res_valid <= 1'b0;
      end else begin
         if (state == S_IDLE && |bus.req) ch <= pick;
         bit_cnt <= (state == S_STREAM) ? bit_cnt + 1'b1 : '0;
         if (state == S_CLR)
            count <= '0;
         else if ((state == S_STREAM || state == S_DRAIN) && seq_seen)
            count <= count + CNT_W'(1);
         if (state == S_REPORT && bus.res_ready)
            rr_ptr <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
         bus.gnt       <= (state_next == S_STREAM) ? (NUM_CH'(1) << ch) : '0;
         bus.res_valid <= (state_next == S_REPORT);
      end
   end

endmodule

// File: doc/seq_frame_scheduler.md
SEQ_FRAME_SCHEDULER -- requirements
Module: seq_frame_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting serial channels (2..8) SHALL be supported.
REQ-002 Parameter FRAME_LEN, default 16, bits per frame (>=4) SHALL be supported.
REQ-003 Port clk  input  1  clock, all logic SHALL be rising-edge clk.
REQ-004 Port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 Port req  input  NUM_CH  per-channel frame request, level.
REQ-006 Port ch_bit  input  NUM_CH  per-channel serial data; only the granted channel's bit SHALL be used.
REQ-007 Port gnt  output  NUM_CH  one-hot grant; the granted channel SHALL present frame bit k on ch_bit in the k-th gnt cycle.
REQ-008 Port res_valid  output  1  frame result available.
REQ-009 Port res_ch  output  $clog2(NUM_CH)  channel index of the reported frame.
REQ-010 Port res_count  output  $clog2(FRAME_LEN+1)  number of 1011 detections in the frame.
REQ-011 Port res_ready  input  1  result consumer accept.

Function
REQ-012 FSM states SHALL be IDLE, CLR, STREAM, DRAIN, REPORT.
REQ-013 IDLE: if any req bit is high, select a channel round-robin starting at rr_ptr, latch its index, go to CLR; else stay.
REQ-014 req SHALL be sampled only in IDLE; a req change during CLR/STREAM/DRAIN SHALL have no effect on the current frame.
REQ-015 CLR: one cycle; the shared detector reset SHALL be asserted; the match count SHALL be cleared; go to STREAM.
REQ-016 STREAM: exactly FRAME_LEN cycles; gnt SHALL be one-hot on the latched channel; the detector input SHALL be ch_bit[channel]; then go to DRAIN.
REQ-017 gnt SHALL be all-zero in every state except STREAM.
REQ-018 In each STREAM and DRAIN cycle, res_count SHALL increment by 1 when the detector output seq_seen is high; the first STREAM cycle never counts because the detector was just cleared.
REQ-019 DRAIN: one cycle capturing a match completed by the last frame bit; go to REPORT.
REQ-020 REPORT: res_valid SHALL be 1 and res_ch/res_count SHALL be stable; on res_valid && res_ready go to IDLE and set rr_ptr to (channel+1) mod NUM_CH.
REQ-021 res_valid SHALL be 0 in all states except REPORT; back-pressure SHALL hold REPORT indefinitely.
REQ-022 Latency: req seen in IDLE cycle t gives CLR at t+1, gnt at t+2..t+FRAME_LEN+1, DRAIN at t+FRAME_LEN+2, res_valid from t+FRAME_LEN+3.
REQ-023 Detection semantics SHALL be the shared detector's (non-overlap restart on 1 after a match to SEQ_1, on 0 to IDLE); the scheduler SHALL NOT reinterpret matches.
REQ-024 res_count SHALL NOT wrap; its width SHALL cover FRAME_LEN.

Reset
REQ-025 On reset: state IDLE, gnt 0, res_valid 0, res_ch 0, res_count 0, rr_ptr 0, detector reset asserted.
REQ-026 A reset during any state, including mid-STREAM or REPORT, SHALL abort the frame with no result reported.
REQ-027 The detector reset SHALL be the OR of the module reset and the CLR state.

Structure
REQ-028 Package seq_sched_pkg SHALL hold the FSM state enum and default NUM_CH/FRAME_LEN constants.
REQ-029 The block SHALL instantiate one seq_detect_1011 as its only sub-module; round-robin selection and the bit counter SHALL be inline.

Verification
REQ-030 req=0001, ch0 frame 1011_0000_0000_0000 -> gnt=0001 for 16 cycles, res_ch=0, res_count=1.
REQ-031 ch1 frame 1011_1011_0000_0000 -> res_ch=1, res_count=2.
REQ-032 ch2 frame 0000_0000_0000_1011 (match on last bit) -> res_count=1 via DRAIN.
REQ-033 req=1111 held, res_ready=1 -> grant order ch0,ch1,ch2,ch3,ch0; res_valid exactly at t+19 after each IDLE accept.
REQ-034 res_ready=0 for 5 cycles in REPORT -> res_valid held, res_ch/res_count stable, gnt=0, then accepted.
REQ-035 reset asserted at the 8th STREAM cycle -> next cycle gnt=0, res_valid=0, rr_ptr=0; a new req=0010 frame then counts from zero correctly.
